// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver. Double-flop synchronises RsRx, finds
// the start-bit centre after half a bit period, then samples each following
// bit at its centre. Good frames update data with a one-cycle valid pulse;
// a low stop bit gives a one-cycle frame_error and parks in BREAK until the
// line returns high.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RsRx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned H  = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          rx_s0_q, rx_s1_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    // Two-flop synchroniser on the asynchronous line; idles high after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s0_q <= 1'b1;
            rx_s1_q <= 1'b1;
        end else begin
            rx_s0_q <= RsRx;
            rx_s1_q <= rx_s0_q;
        end
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic: half-bit wait to the start centre, then full-bit
    // waits between samples; pulses default low so each lasts one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s1_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s1_q) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s1_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s1_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                if (rx_s1_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Asynchronous serial receiver for the Basys3 UART path: samples the `RsRx` pin, recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) and presents each byte with a one-cycle valid strobe. It is the downstream counterpart of the transmitter: it consumes the same line format that the transmitter drives on `RsTx`, including idle-high and LSB-first order. It runs on the fast system clock and uses a parameterised bit period to find the bit centres.

## Interface
- `CLKS_PER_BIT`, default 16: system clock cycles per serial bit.
  - Legal values: ≥ 4.
  - `H = CLKS_PER_BIT/2` (integer floor).
- `clk` input 1: system clock; all logic on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `RsRx` input 1: asynchronous serial line, idle high.
- `data` output 8: last correctly framed byte; held until the next good frame.
- `valid` output 1: one-cycle pulse when `data` updates.
- `frame_error` output 1: one-cycle pulse when the stop bit is sampled low.
- `busy` output 1: high in every state except IDLE.

## Operation
- Synchroniser: a 2-flop chain `RsRx` → `rx_s0` → `rx_s1`; both flops reset to 1. The FSM uses only `rx_s1`.
- Counters:
  - Cycle counter of width `$clog2(CLKS_PER_BIT)`.
  - 3-bit bit index.
  - 8-bit shift register; shifts right, new bit enters at bit 7, so byte order is LSB first.
- States:
  - IDLE: if `rx_s1`==0 → START, clear the cycle counter.
  - START: wait H cycles, then sample `rx_s1`.
    - If 0 → DATA, with counter=0 and index=0.
    - If 1 → IDLE (glitch). No outputs change.
  - DATA: wait CLKS_PER_BIT cycles, then sample `rx_s1` into the shift register and increment the index. After the 8th sample → STOP.
  - STOP: wait CLKS_PER_BIT cycles, then sample `rx_s1`.
    - If 1: load `data` from the shift register, pulse `valid`, go to IDLE.
    - If 0: pulse `frame_error`, leave `data` unchanged, go to BREAK.
  - BREAK: stay until `rx_s1`==1, then go to IDLE. A held-low line (break) therefore produces exactly one `frame_error` and no further frames.
- Rules that apply in every state:
  - `valid` and `frame_error` are never high together.
  - Each pulse lasts exactly one cycle.
- Reset (`rst_n`=0 at a rising edge), in any state including mid-frame:
  - Next state is IDLE.
  - Counters and shift register → 0.
  - `data`=0x00, `valid`=0, `frame_error`=0, `busy`=0.
  - `rx_s0` = `rx_s1` = 1.
  - A frame in progress is discarded with no pulse.

## Timing
- Define edge 0 as the first rising edge at which `RsRx` is sampled low by `rx_s0`.
- `rx_s1` is low after edge 1; the FSM enters START at edge 2, and `busy` is high from edge 2.
- Start-bit check is at edge 2+H.
- Data bit i (i=0..7) is sampled at edge 2+H+(i+1)·CLKS_PER_BIT.
- Stop bit is sampled at edge 2+H+9·CLKS_PER_BIT.
  - `valid` or `frame_error` is high for the single cycle following that edge.
  - The FSM is in IDLE, or BREAK on a framing error, after that edge.
- Example, CLKS_PER_BIT=16: start check at edge 10, stop sample at edge 154.
- Back-to-back frames: a new start bit whose falling edge reaches `rx_s1` during or after the cycle IDLE is re-entered is accepted. There is no dead time beyond the stop-bit sample point.
- A glitch shorter than H cycles returns the FSM to IDLE at edge 2+H; `busy` drops in the following cycle.
- Tolerance: sampling at mid-bit tolerates roughly ±4% baud mismatch. The bench uses an exact bit period.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `RsRx` toggling.
  - Required: `data`=0x00, `valid`=0, `frame_error`=0, `busy`=0 throughout.
  - Required: no pulse after release with the line held high.
- Single frame 0xA5, CLKS_PER_BIT=16, bit period 16 cycles.
  - Required: `valid` high for exactly the cycle after edge 154, with `data`=0xA5.
  - Required: `busy` high from edge 2 through edge 154.
- Back-to-back 0x00 then 0xFF with no idle gap between the stop bit and the next start bit.
  - Required: two `valid` pulses 160 cycles apart, with `data`=0x00 then `data`=0xFF.
- Glitch: `RsRx` low for 3 cycles, then high.
  - Required: `busy` high from edge 2 to edge 10, then low.
  - Required: no `valid`, no `frame_error`, `data` unchanged.
- Framing error/break: send 0x3C correctly, then start bit + 0x55 + stop bit driven 0, with the line held low for 200 more cycles.
  - Required: one `frame_error` pulse at the second frame's stop sample.
  - Required: `data` stays 0x3C and `busy` stays high in BREAK.
  - Required: `busy` falls within 3 cycles of the line returning high; a following 0x81 frame is received correctly.
- Reset mid-frame: assert `rst_n`=0 for 1 cycle at edge 80 of a 0x7E frame.
  - Required: no pulse.
  - Required: `busy`=0 in the cycle after the reset edge.
  - Required: the next full frame 0x12 is received with `valid`.
